// File: rtl/decode_stage.sv
// decode_stage: decodes NUM_LANES RV32I instructions per cycle. The decoded
// bundles wait in a DEPTH-entry in-order queue with valid/ready on both sides.
// Optional feature macro: DECODE_RV32M_EN adds the RV32M multiply/divide
// decodes (aluFunc 10..17). aluFunc then needs 5 bits per lane instead of 4.
module decode_stage #(
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 4,
    parameter int PC_W      = 32,
`ifdef DECODE_RV32M_EN
    localparam int ALU_W    = 5
`else
    localparam int ALU_W    = 4
`endif
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      flush_in,
    input  logic                      valid_in,
    output logic                      ready_out,
    input  logic [NUM_LANES-1:0]      lane_valid_in,
    input  logic [NUM_LANES*32-1:0]   instruction_in,
    input  logic [PC_W-1:0]           pc_in,
    output logic                      valid_out,
    input  logic                      ready_in,
    output logic [NUM_LANES-1:0]      lane_valid_out,
    output logic [NUM_LANES*4-1:0]    iType_out,
    output logic [NUM_LANES*ALU_W-1:0] aluFunc_out,
    output logic [NUM_LANES*3-1:0]    brFunc_out,
    output logic [NUM_LANES*32-1:0]   imm_out,
    output logic [NUM_LANES*PC_W-1:0] pc_out,
    output logic [NUM_LANES*5-1:0]    rd_out,
    output logic [NUM_LANES*5-1:0]    rs1_out,
    output logic [NUM_LANES*5-1:0]    rs2_out,
    output logic [NUM_LANES-1:0]      illegal_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [ALU_W-1:0] ALU_ADD  = 0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 1;
    localparam logic [ALU_W-1:0] ALU_AND  = 2;
    localparam logic [ALU_W-1:0] ALU_OR   = 3;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4;
    localparam logic [ALU_W-1:0] ALU_SLT  = 5;
    localparam logic [ALU_W-1:0] ALU_SLTU = 6;
    localparam logic [ALU_W-1:0] ALU_SLL  = 7;
    localparam logic [ALU_W-1:0] ALU_SRL  = 8;
    localparam logic [ALU_W-1:0] ALU_SRA  = 9;
`ifdef DECODE_RV32M_EN
    localparam logic [ALU_W-1:0] ALU_MUL  = 10;
`endif

    typedef enum logic [3:0] {
        IT_OP = 4'd0, IT_OPIMM = 4'd1, IT_BRANCH = 4'd2, IT_LUI = 4'd3, IT_JAL = 4'd4,
        IT_JALR = 4'd5, IT_LOAD = 4'd6, IT_STORE = 4'd7, IT_AUIPC = 4'd8
    } itype_e;

    typedef enum logic [2:0] {
        BR_EQ = 3'd0, BR_NEQ = 3'd1, BR_LT = 3'd2, BR_LTU = 3'd3,
        BR_GE = 3'd4, BR_GEU = 3'd5, BR_DBR = 3'd6
    } brfunc_e;

    typedef struct packed {
        logic             lane_valid;
        logic             illegal;
        itype_e           itype;
        logic [ALU_W-1:0] alu;
        brfunc_e          br;
        logic [31:0]      imm;
        logic [PC_W-1:0]  pc;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
    } lane_t;

    // Decode one instruction into its queue payload. Unused fields stay 0, and
    // an undecodable lane collapses to a zeroed OP/Add/Dbr slot with illegal set.
    function automatic lane_t decode_lane(input logic [31:0] ins, input logic present,
                                          input logic [PC_W-1:0] lane_pc);
        lane_t      d;
        logic       ok;
        logic [2:0] f3;
        logic [6:0] f7;
        f3      = ins[14:12];
        f7      = ins[31:25];
        d       = '0;
        d.itype = IT_OP;
        d.alu   = ALU_ADD;
        d.br    = BR_DBR;
        ok      = (ins[1:0] == 2'b11);
        case (ins[6:0])
            OPC_OP: begin
                d.itype = IT_OP;
                d.rd    = ins[11:7];
                d.rs1   = ins[19:15];
                d.rs2   = ins[24:20];
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:  d.alu = ALU_ADD;
                            3'b001:  d.alu = ALU_SLL;
                            3'b010:  d.alu = ALU_SLT;
                            3'b011:  d.alu = ALU_SLTU;
                            3'b100:  d.alu = ALU_XOR;
                            3'b101:  d.alu = ALU_SRL;
                            3'b110:  d.alu = ALU_OR;
                            default: d.alu = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (f3 == 3'b000)      d.alu = ALU_SUB;
                        else if (f3 == 3'b101) d.alu = ALU_SRA;
                        else                   ok = 1'b0;
                    end
`ifdef DECODE_RV32M_EN
                    7'b0000001: d.alu = ALU_MUL + ALU_W'(f3);
`endif
                    default: ok = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                d.itype = IT_OPIMM;
                d.rd    = ins[11:7];
                d.rs1   = ins[19:15];
                d.imm   = {{20{ins[31]}}, ins[31:20]};
                case (f3)
                    3'b000:  d.alu = ALU_ADD;
                    3'b010:  d.alu = ALU_SLT;
                    3'b011:  d.alu = ALU_SLTU;
                    3'b100:  d.alu = ALU_XOR;
                    3'b110:  d.alu = ALU_OR;
                    3'b111:  d.alu = ALU_AND;
                    3'b001: begin
                        d.alu = ALU_SLL;
                        if (f7 != 7'b0000000) ok = 1'b0;
                    end
                    default: begin
                        if (f7 == 7'b0000000)      d.alu = ALU_SRL;
                        else if (f7 == 7'b0100000) d.alu = ALU_SRA;
                        else                       ok = 1'b0;
                    end
                endcase
            end
            OPC_BRANCH: begin
                d.itype = IT_BRANCH;
                d.rs1   = ins[19:15];
                d.rs2   = ins[24:20];
                d.imm   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                case (f3)
                    3'b000:  d.br = BR_EQ;
                    3'b001:  d.br = BR_NEQ;
                    3'b100:  d.br = BR_LT;
                    3'b101:  d.br = BR_GE;
                    3'b110:  d.br = BR_LTU;
                    3'b111:  d.br = BR_GEU;
                    default: ok = 1'b0;
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                d.itype = (ins[6:0] == OPC_LUI) ? IT_LUI : IT_AUIPC;
                d.rd    = ins[11:7];
                d.imm   = {ins[31:12], 12'b0};
            end
            OPC_JAL: begin
                d.itype = IT_JAL;
                d.rd    = ins[11:7];
                d.imm   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD: begin
                d.itype = (ins[6:0] == OPC_JALR) ? IT_JALR : IT_LOAD;
                d.rd    = ins[11:7];
                d.rs1   = ins[19:15];
                d.imm   = {{20{ins[31]}}, ins[31:20]};
                if (ins[6:0] == OPC_JALR) begin
                    if (f3 != 3'b000) ok = 1'b0;
                end else if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) begin
                    ok = 1'b0;
                end
            end
            OPC_STORE: begin
                d.itype = IT_STORE;
                d.rs1   = ins[19:15];
                d.rs2   = ins[24:20];
                d.imm   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                if (f3 > 3'b010) ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            d         = '0;
            d.br      = BR_DBR;
            d.illegal = 1'b1;
        end
        d.pc         = lane_pc;
        d.lane_valid = 1'b1;
        if (!present) d = '0;
        return d;
    endfunction

    lane_t            dec  [NUM_LANES];
    lane_t            head [NUM_LANES];
    lane_t            mem  [DEPTH][NUM_LANES];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign ready_out = (count < CNT_W'(DEPTH));
    assign valid_out = (count != '0);
    assign push      = valid_in & ready_out & ~flush_in;
    assign pop       = valid_out & ready_in;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign dec[g] = decode_lane(instruction_in[32*g +: 32], lane_valid_in[g],
                                    pc_in + PC_W'(4 * g));

        assign lane_valid_out[g]           = head[g].lane_valid;
        assign illegal_out[g]              = head[g].illegal;
        assign iType_out[4*g +: 4]         = head[g].itype;
        assign aluFunc_out[ALU_W*g +: ALU_W] = head[g].alu;
        assign brFunc_out[3*g +: 3]        = head[g].br;
        assign imm_out[32*g +: 32]         = head[g].imm;
        assign pc_out[PC_W*g +: PC_W]      = head[g].pc;
        assign rd_out[5*g +: 5]            = head[g].rd;
        assign rs1_out[5*g +: 5]           = head[g].rs1;
        assign rs2_out[5*g +: 5]           = head[g].rs2;
    end

    // Present the head entry, forced to zero whenever the queue is empty.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path; a missed path infers a latch.
        for (int i = 0; i < NUM_LANES; i++) begin
            head[i] = '0;
            if (valid_out) head[i] = mem[rd_ptr][i];
        end
    end

    // Write the decoded bundle into the tail slot on an accepted push.
    always_ff @(posedge clk_in) begin
        // NOTE: the payload array has no reset; outputs are masked by valid_out, so stale slots never leak out.
        if (push) mem[wr_ptr] <= dec;
    end

    // Queue pointers and occupancy; flush and reset both empty the queue.
    always_ff @(posedge clk_in or negedge rst_in) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised successor to the single-instruction combinational decoder.
- Decodes a bundle of NUM_LANES RV32I instructions per cycle.
- Buffers the decoded bundles in a DEPTH-entry in-order queue, with valid/ready handshakes on both sides.
- Sits between fetch and rename/dispatch. Supports a pipeline flush and per-lane illegal-instruction flags.

Parameters:
- NUM_LANES, 2, instructions per bundle (1..4)
- DEPTH, 4, decoded-bundle queue entries (power of 2, >=2)
- PC_W, 32, program counter width

Ports:
- clk_in  in  1  clock, rising edge
- rst_in  in  1  reset, asynchronous, active-low
- flush_in  in  1  discard all queued bundles and the same-cycle input
- valid_in  in  1  input bundle valid
- ready_out  out  1  stage can accept a bundle
- lane_valid_in  in  NUM_LANES  per-lane instruction present
- instruction_in  in  NUM_LANES*32  lane i at [32i+31:32i]
- pc_in  in  PC_W  PC of lane 0
- valid_out  out  1  head bundle valid
- ready_in  in  1  downstream accepts head bundle
- lane_valid_out  out  NUM_LANES  per-lane valid of head bundle
- iType_out  out  NUM_LANES*4  OP=0, OPIMM=1, BRANCH=2, LUI=3, JAL=4, JALR=5, LOAD=6, STORE=7, AUIPC=8
- aluFunc_out  out  NUM_LANES*4  Add=0, Sub=1, And=2, Or=3, Xor=4, Slt=5, Sltu=6, Sll=7, Srl=8, Sra=9
- brFunc_out  out  NUM_LANES*3  Eq=0, Neq=1, Lt=2, Ltu=3, Ge=4, Geu=5, Dbr=6
- imm_out  out  NUM_LANES*32  sign-extended immediate
- pc_out  out  NUM_LANES*PC_W  per-lane PC
- rd_out, rs1_out, rs2_out  out  NUM_LANES*5 each  register indices
- illegal_out  out  NUM_LANES  lane held an undecodable instruction

Behaviour:
- Reset (rst_in=0, asynchronous):
  - queue emptied; read and write pointers = 0, count = 0.
  - valid_out = 0, ready_out = 1.
  - All payload outputs = 0.
  - Reset mid-transfer loses all queued bundles; no partial state survives.
- Handshake:
  - ready_out = (count < DEPTH), driven from registers only; no combinational path from ready_in.
  - Push when valid_in & ready_out & !flush_in.
  - Pop when valid_out & ready_in.
  - Push and pop in the same cycle leave count unchanged.
  - The bundle is accepted all-or-nothing.
  - An all-zero lane_valid_in bundle is still enqueued.
- Latency: a bundle pushed at edge N is visible with valid_out=1 after edge N, i.e. one cycle of latency when the queue is empty.
- Outputs come from registered queue storage, never combinationally from the inputs.
- Per-lane decode (combinational, before enqueue):
  - Field extraction:
    - rd = instr[11:7], rs1 = instr[19:15], rs2 = instr[24:20].
    - Fields not used by the format are forced to 0.
  - PC: lane i pc_out = pc_in + 4*i, mod 2^PC_W (wraps).
  - Immediates use the I/S/B/U/J formats, sign-extended; the U immediate is instr[31:12]<<12.
  - OP: funct3/funct7 select aluFunc; Sub/Sra require funct7 = 0100000.
  - OPIMM: Srai requires funct7 = 0100000; Slli/Srli require funct7 = 0.
  - BRANCH: funct3 selects brFunc; funct3 010/011 are illegal.
  - Non-branch instructions: brFunc = Dbr.
  - LOAD/STORE/LUI/AUIPC/JAL/JALR: aluFunc = Add.
  - Illegal cases: unknown opcode, funct3 or funct7 (including the decoder-defined opcodes above), or instr[1:0] != 11. An illegal lane is:
    - illegal_out = 1
    - iType = OP, aluFunc = Add, brFunc = Dbr
    - imm = 0, all register fields = 0
    - still enqueued, with its lane_valid preserved
  - Lanes with lane_valid_in = 0: all payload = 0 and illegal = 0.
- Flush:
  - flush_in=1 at an edge sets count = 0 and pointers = 0.
  - Any same-cycle push is dropped; a same-cycle pop has no effect.
  - valid_out = 0 and ready_out = 1 from the next cycle.
- Full boundary: with count = DEPTH, ready_out = 0 and valid_in is ignored, even when a pop occurs that cycle. ready_out rises the cycle after the pop.
- Pointer wrap: pointers wrap modulo DEPTH; bundle order is strictly FIFO.

Optional Feature:
- Macro: DECODE_RV32M_EN.
- Defined: OP with funct7 = 0000001 decodes to aluFunc Mul=10, Mulh=11, Mulhsu=12, Mulhu=13, Div=14, Divu=15, Rem=16, Remu=17 (by funct3), with iType = OP.
- Undefined: those encodings are flagged illegal_out = 1. aluFunc never exceeds 9.

Test Plan:
- Decode and imm:
  - Lane0 0x00D605B3, lane1 0x00158593, pc_in = 0x100 -> after 1 cycle: valid_out = 1.
  - Lane0: OP, Add, rd=11, rs1=12, rs2=13, pc=0x100.
  - Lane1: OPIMM, Add, rd=11, rs1=11, imm=1, pc=0x104.
  - Both lanes: brFunc = Dbr.
- Branch: 0xFE000EE3 -> BRANCH, Eq, imm = 0xFFFFFFFC, rs1 = rs2 = 0, rd = 0.
- Backpressure:
  - ready_in = 0, push 5 bundles -> ready_out falls after the 4th push and the 5th is not accepted.
  - Then ready_in = 1 -> bundles drain in order; ready_out = 1 the cycle after the first pop.
- Flush: queue holds 3 bundles; assert flush_in together with valid_in -> next cycle valid_out = 0, ready_out = 1, nothing from the flushed input appears.
- Reset mid-operation: drop rst_in asynchronously between edges with 2 bundles queued -> valid_out = 0 immediately, all outputs 0; post-reset push decodes normally.
- Illegal / M-extension: 0x02C58533 and 0x00000000:
  - Without the macro: both illegal_out = 1.
  - With DECODE_RV32M_EN: first lane is aluFunc = Mul, rd=10, rs1=11, rs2=12, illegal_out = 0; second lane remains illegal_out = 1.
